// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    localparam int UART_DATA_BITS          = 8;
    localparam int UART_DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    logic meta;

    // Double-register the line so downstream logic sees a settled level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            out  <= 1'b1;
        end else begin
            meta <= in;
            out  <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 framing, oversampled by the external tick `en`,
// with start-bit glitch rejection, one-entry holding register and overrun flag.
// Optional: define UART_RX_STOP_CHECK_EN to sample the stop bit into frame_err.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_DEFAULT_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in,
    output logic [UART_DATA_BITS-1:0] out,
    output logic                      valid,
    input  logic                      rd,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int             CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(OVERSAMPLE - 1);

    uart_rx_state_t             state, state_next;
    logic [CW-1:0]              cnt, cnt_next;
    logic [2:0]                 bit_idx, bit_idx_next;
    logic [UART_DATA_BITS-1:0]  shreg;
    logic                       in_s;
    logic                       shift_en;
    logic                       frame_done;
    logic                       accept;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (in_s)
    );

    assign busy   = (state != IDLE);
    // A completed frame is taken when the holder is empty or being read this cycle.
    assign accept = frame_done && (!valid || rd);

    // FSM and tick/bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
        end
    end

    // Next-state, counter and strobe decode; everything advances only on `en` ticks.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_en     = 1'b0;
        frame_done   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (!in_s) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt_next = '0;
                        if (!in_s) begin
                            state_next   = DATA;
                            bit_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shift_en = 1'b1;
                        cnt_next = '0;
                        if (bit_idx == 3'd7) begin
                            state_next = STOP;
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        frame_done = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Capture each data bit at its centre, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg[bit_idx] <= in_s;
        end
    end

    // Holding register with valid/read handshake and overrun reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (accept) begin
            out   <= shreg;
            valid <= 1'b1;
            if (rd) begin
                overrun <= 1'b0;
            end
        end else if (frame_done) begin
            overrun <= 1'b1;
        end else if (rd && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_STOP_CHECK_EN
    // Stop bit sampled low marks the byte in `out` as mis-framed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (accept) begin
            frame_err <= ~in_s;
        end else if (rd && valid) begin
            frame_err <= 1'b0;
        end
    end
`else
    assign frame_err = 1'b0;
`endif

endmodule
